lsu: RTL

Load/store unit that sits directly downstream of the execute stage and consumes its memory-operation outputs. It drives a word-wide data memory through a request/grant/response handshake and stalls the pipeline while an access is outstanding. Stores are formatted into byte enables. Load data is extracted, extended and returned to the register file as a one-cycle write-back.

---
 rtl/lsu.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit: request/grant/response memory handshake, store byte-lane formatting, load extraction and write-back.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned half/word requests instead of issuing them.
module lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_addr_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        rd_wen_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        err_o,
    output logic        misalign_o
);

    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             we_q;
    logic             uns_q;
    logic [1:0]       size_q;
    logic [1:0]       off_q;
    logic [4:0]       rd_q;

    logic             misaligned_c;
    logic             accept_c;
    logic             done_c;
    logic             timeout_hit_c;
    logic [3:0]       be_c;
    logic [31:0]      wdata_c;
    logic [31:0]      ldata_c;
    logic [7:0]       lbyte_c;
    logic [15:0]      lhalf_c;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;

    assign misaligned_c = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                          (req_size_i[1] && (req_addr_i[1:0] != 2'b00));

    // Trapped requests are never latched; only the pulse is recorded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= (state_q == S_IDLE) && req_valid_i && misaligned_c;
        end
    end

    assign misalign_o = misalign_q;
`else
    assign misaligned_c = 1'b0;
    assign misalign_o   = 1'b0;
`endif

    // Next-state, stall and completion strobes.
    always_comb begin
        state_d       = state_q;
        accept_c      = 1'b0;
        done_c        = 1'b0;
        timeout_hit_c = 1'b0;
        stall_o       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i && !misaligned_c) begin
                    accept_c = 1'b1;
                    stall_o  = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                stall_o = 1'b1;
                if (mem_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout_hit_c = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Store lane formatting from the incoming request.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = req_wdata_i;
        case (req_size_i)
            2'b00: begin
                be_c    = 4'b0001 << req_addr_i[1:0];
                wdata_c = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                be_c    = req_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{req_wdata_i[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = req_wdata_i;
            end
        endcase
    end

    // Load extraction and extension from the latched request.
    always_comb begin
        lbyte_c = mem_rdata_i[{off_q, 3'b000} +: 8];
        lhalf_c = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (size_q)
            2'b00:   ldata_c = uns_q ? {24'h0, lbyte_c} : {{24{lbyte_c[7]}}, lbyte_c};
            2'b01:   ldata_c = uns_q ? {16'h0, lhalf_c} : {{16{lhalf_c[15]}}, lhalf_c};
            default: ldata_c = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            rd_q        <= 5'd0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'b0000;
            mem_addr_o  <= 32'h0;
            mem_wdata_o <= 32'h0;
            rd_wen_o    <= 1'b0;
            rd_addr_o   <= 5'd0;
            rd_data_o   <= 32'h0;
            err_o       <= 1'b0;
        end else begin
            rd_wen_o <= 1'b0;
            err_o    <= 1'b0;
            if (accept_c) begin
                we_q        <= req_we_i;
                uns_q       <= req_unsigned_i;
                size_q      <= req_size_i;
                off_q       <= req_addr_i[1:0];
                rd_q        <= req_rd_addr_i;
                mem_req_o   <= 1'b1;
                mem_we_o    <= req_we_i;
                mem_be_o    <= be_c;
                mem_addr_o  <= {req_addr_i[31:2], 2'b00};
                mem_wdata_o <= wdata_c;
            end
            if ((state_q == S_REQ) && mem_gnt_i) begin
                cnt_q       <= '0;
                mem_req_o   <= 1'b0;
                mem_we_o    <= 1'b0;
                mem_be_o    <= 4'b0000;
                mem_addr_o  <= 32'h0;
                mem_wdata_o <= 32'h0;
            end
            if ((state_q == S_WAIT) && !mem_rvalid_i && !timeout_hit_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            // Register 0 is hard-wired, so its write-back is dropped.
            if (done_c && !we_q && (rd_q != 5'd0)) begin
                rd_wen_o  <= 1'b1;
                rd_addr_o <= rd_q;
                rd_data_o <= ldata_c;
            end
            if (timeout_hit_c) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule
